// File: rtl/lif_tdm_scheduler_pkg.sv
// Shared types and constants for the time-multiplexed LIF neuron scheduler.
// Holds the sweep FSM encoding, the membrane/current width and the default threshold.
package lif_tdm_scheduler_pkg;

   localparam int STATE_W        = 4;
   localparam int DEFAULT_THRESH = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } sched_state_e;

endpackage

// File: rtl/lif_evt_fifo.sv
// Small synchronous FIFO carrying spike indices from the scheduler to the consumer.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module lif_evt_fifo #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_pop;
   logic             do_push;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

   // Pointers carry an extra wrap bit so full and empty can be told apart.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/lif_tdm_scheduler.sv
// Leaky integrate-and-fire neurons sharing one update datapath, swept one neuron per cycle.
// Spiking neurons push their index into an event FIFO; a full FIFO stalls the sweep.
module lif_tdm_scheduler
   import lif_tdm_scheduler_pkg::*;
#(
   parameter int N_NEUR     = 8,
   parameter int THRESH     = DEFAULT_THRESH,
   parameter int FIFO_DEPTH = 4,
   localparam int IW        = $clog2(N_NEUR)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               cur_we,
   input  logic [IW-1:0]      cur_idx,
   input  logic [STATE_W-1:0] cur_data,
   input  logic               tick,
   output logic               busy,
   output logic               done,
   output logic               tick_drop,
   output logic               spk_valid,
   input  logic               spk_ready,
   output logic [IW-1:0]      spk_idx,
   input  logic [IW-1:0]      rd_idx,
   output logic [STATE_W-1:0] rd_state
);

   localparam logic [STATE_W-1:0] THRESH_V = STATE_W'(THRESH);
   localparam logic [IW-1:0]      LAST_IDX = IW'(N_NEUR - 1);

   logic [STATE_W-1:0] cur_tab [N_NEUR];
   logic [STATE_W-1:0] st_tab  [N_NEUR];

   sched_state_e       fsm;
   logic [IW-1:0]      idx;
   logic               pending;

   logic [STATE_W-1:0] cur_k;
   logic [STATE_W-1:0] st_k;
   logic [STATE_W-1:0] next_st;
   logic               fired;
   logic               fifo_full;
   logic               fifo_empty;
   logic               fifo_pop;
   logic               stall;
   logic               update_en;
   logic               fifo_push;

   // The single shared LIF datapath: a firing neuron resets to its input current.
   always_comb begin
      cur_k   = cur_tab[idx];
      st_k    = st_tab[idx];
      fired   = (st_k >= THRESH_V);
      next_st = cur_k + (fired ? '0 : (st_k >> 1));
   end

   assign spk_valid = !fifo_empty;
   assign fifo_pop  = spk_valid && spk_ready;
   assign stall     = fired && fifo_full && !fifo_pop;
   assign update_en = (fsm == SWEEP) && !stall;
   assign fifo_push = update_en && fired;
   assign rd_state  = st_tab[rd_idx];

   // Current writes land at the edge, so an update in the same cycle still sees the old value.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < N_NEUR; i++) begin
            cur_tab[i] <= '0;
         end
      end else if (cur_we) begin
         cur_tab[cur_idx] <= cur_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < N_NEUR; i++) begin
            st_tab[i] <= '0;
         end
      end else if (update_en) begin
         st_tab[idx] <= next_st;
      end
   end

   // Sweep control; a tick arriving mid-sweep is remembered once, further ones are dropped.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         fsm       <= IDLE;
         idx       <= '0;
         pending   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         tick_drop <= 1'b0;
      end else begin
         done      <= 1'b0;
         tick_drop <= 1'b0;
         case (fsm)
            IDLE: begin
               if (tick || pending) begin
                  fsm     <= SWEEP;
                  busy    <= 1'b1;
                  idx     <= '0;
                  pending <= 1'b0;
               end
            end
            SWEEP: begin
               if (tick) begin
                  if (pending) begin
                     tick_drop <= 1'b1;
                  end else begin
                     pending <= 1'b1;
                  end
               end
               if (update_en) begin
                  if (idx == LAST_IDX) begin
                     fsm  <= IDLE;
                     busy <= 1'b0;
                     done <= 1'b1;
                     idx  <= '0;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            default: begin
               fsm  <= IDLE;
               busy <= 1'b0;
            end
         endcase
      end
   end

   lif_evt_fifo #(
      .WIDTH (IW),
      .DEPTH (FIFO_DEPTH)
   ) u_evt_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (fifo_push),
      .push_data (idx),
      .pop       (fifo_pop),
      .head      (spk_idx),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

endmodule

// File: tb/tb_lif_tdm_scheduler.sv
// Scoreboard bench for lif_tdm_scheduler: stimulus queues expected spike indices,
// a negedge monitor pops and compares them whenever an event is handed over.
module tb_lif_tdm_scheduler;

   localparam int N  = 8;
   localparam int IW = 3;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          cur_we;
   logic [IW-1:0] cur_idx;
   logic [3:0]    cur_data;
   logic          tick;
   logic          busy;
   logic          done;
   logic          tick_drop;
   logic          spk_valid;
   logic          spk_ready;
   logic [IW-1:0] spk_idx;
   logic [IW-1:0] rd_idx;
   logic [3:0]    rd_state;

   int checks     = 0;
   int errors     = 0;
   int done_count = 0;
   int drop_count = 0;
   int exp_idx;
   int exp_q[$];
   int model_cur[N];
   int model_st[N];
   int d0;
   int t0;

   lif_tdm_scheduler #(
      .N_NEUR     (N),
      .THRESH     (8),
      .FIFO_DEPTH (4)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .cur_we    (cur_we),
      .cur_idx   (cur_idx),
      .cur_data  (cur_data),
      .tick      (tick),
      .busy      (busy),
      .done      (done),
      .tick_drop (tick_drop),
      .spk_valid (spk_valid),
      .spk_ready (spk_ready),
      .spk_idx   (spk_idx),
      .rd_idx    (rd_idx),
      .rd_state  (rd_state)
   );

   always #50 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   // Monitor: every accepted spike event is matched against the scoreboard queue.
   always @(negedge clk) begin
      if (reset_n) begin
         if (done) done_count++;
         if (tick_drop) drop_count++;
         if (spk_valid && spk_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL spk_unexpected actual=%0d expected=none", spk_idx);
            end else begin
               exp_idx = exp_q.pop_front();
               checkOutput("spk_idx", 32'(spk_idx), 32'(exp_idx));
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic applyStimulus(input int idx, input int data);
      cur_we   = 1'b1;
      cur_idx  = IW'(idx);
      cur_data = 4'(data);
      @(posedge clk); #1;
      cur_we = 1'b0;
      model_cur[idx] = data;
   endtask

   task automatic writeAll(input int data);
      for (int i = 0; i < N; i++) applyStimulus(i, data);
   endtask

   task automatic doReset();
      reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      exp_q.delete();
      for (int i = 0; i < N; i++) begin
         model_cur[i] = 0;
         model_st[i]  = 0;
      end
   endtask

   // Reference sweep: expected spikes are queued before the DUT can produce them.
   task automatic modelSweep();
      bit f;
      for (int k = 0; k < N; k++) begin
         f = (model_st[k] >= 8);
         if (f) exp_q.push_back(k);
         model_st[k] = (model_cur[k] + (f ? 0 : (model_st[k] >> 1))) & 15;
      end
   endtask

   task automatic checkStates(input string name);
      for (int i = 0; i < N; i++) begin
         rd_idx = IW'(i);
         #1;
         checkOutput(name, 32'(rd_state), 32'(model_st[i]));
      end
   endtask

   // Stall-free sweep with exact busy/done cycle timing.
   task automatic runSweep(input string name);
      modelSweep();
      tick = 1'b1;
      @(posedge clk); #1;
      tick = 1'b0;
      checkOutput({name, "_busy_start"}, 32'(busy), 1);
      repeat (N - 1) @(posedge clk);
      #1;
      checkOutput({name, "_done_early"}, 32'(done), 0);
      @(posedge clk); #1;
      checkOutput({name, "_done"}, 32'(done), 1);
      checkOutput({name, "_busy_end"}, 32'(busy), 0);
   endtask

   task automatic waitDone(input string name, input int max_cycles);
      int n;
      n = 0;
      while (done !== 1'b1 && n < max_cycles) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput({name, "_done_seen"}, 32'(done), 1);
   endtask

   initial begin
      reset_n   = 1'b0;
      cur_we    = 1'b0;
      cur_idx   = '0;
      cur_data  = '0;
      tick      = 1'b0;
      spk_ready = 1'b1;
      rd_idx    = '0;
      repeat (2) @(posedge clk);
      #1;
      doReset();

      checkOutput("rst_busy", 32'(busy), 0);
      checkOutput("rst_done", 32'(done), 0);
      checkOutput("rst_drop", 32'(tick_drop), 0);
      checkOutput("rst_valid", 32'(spk_valid), 0);
      checkOutput("rst_spk_idx", 32'(spk_idx), 0);
      checkStates("rst_state");

      // Constant sub-threshold drive: 0 -> 3 -> 4, one done per sweep.
      d0 = done_count;
      writeAll(3);
      runSweep("c3_s1");
      checkStates("c3_s1_state");
      runSweep("c3_s2");
      checkStates("c3_s2_state");
      rd_idx = 3'd5; #1;
      checkOutput("c3_s2_hand", 32'(rd_state), 4);
      @(posedge clk); #1;
      checkOutput("c3_done_count", 32'(done_count - d0), 2);

      // Single neuron reaching threshold, spiking on the second sweep.
      doReset();
      applyStimulus(2, 8);
      runSweep("n2_s1");
      checkStates("n2_s1_state");
      runSweep("n2_s2");
      checkStates("n2_s2_state");
      rd_idx = 3'd2; #1;
      checkOutput("n2_s2_hand", 32'(rd_state), 8);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("n2_q_empty", 32'(exp_q.size()), 0);

      // Leak arithmetic and 4-bit wrap: 12+3=15, 14+3 wraps to 1.
      doReset();
      applyStimulus(0, 7);
      applyStimulus(1, 6);
      runSweep("wr_s1");
      applyStimulus(0, 12);
      applyStimulus(1, 14);
      runSweep("wr_s2");
      rd_idx = 3'd0; #1;
      checkOutput("wr_sum15", 32'(rd_state), 15);
      rd_idx = 3'd1; #1;
      checkOutput("wr_wrap1", 32'(rd_state), 1);

      // Saturated drive: the third sweep stalls on a full FIFO until the consumer drains it.
      doReset();
      writeAll(15);
      runSweep("st_s1");
      runSweep("st_s2");
      repeat (4) @(posedge clk);
      #1;
      checkOutput("st_s2_q_empty", 32'(exp_q.size()), 0);
      spk_ready = 1'b0;
      d0 = done_count;
      modelSweep();
      tick = 1'b1;
      @(posedge clk); #1;
      tick = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      checkOutput("st_busy_held", 32'(busy), 1);
      checkOutput("st_no_done", 32'(done_count - d0), 0);
      checkOutput("st_valid", 32'(spk_valid), 1);
      checkOutput("st_head", 32'(spk_idx), 0);
      spk_ready = 1'b1;
      waitDone("st_s3", 40);
      repeat (6) @(posedge clk);
      #1;
      checkOutput("st_drained", 32'(exp_q.size()), 0);
      checkOutput("st_fifo_empty", 32'(spk_valid), 0);
      checkStates("st_s3_state");

      // Extra ticks mid-sweep: one becomes pending, two are dropped.
      doReset();
      d0 = done_count;
      t0 = drop_count;
      tick = 1'b1;
      @(posedge clk); #1;
      tick = 1'b0;
      @(posedge clk); #1;
      tick = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      tick = 1'b0;
      waitDone("pd_s1", 20);
      @(posedge clk); #1;
      checkOutput("pd_b2b_busy", 32'(busy), 1);
      waitDone("pd_s2", 20);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("pd_idle_after", 32'(busy), 0);
      checkOutput("pd_drops", 32'(drop_count - t0), 2);
      checkOutput("pd_dones", 32'(done_count - d0), 2);

      // Reset in the middle of a sweep aborts it with no done pulse.
      doReset();
      writeAll(9);
      runSweep("ra_s1");
      spk_ready = 1'b0;
      tick = 1'b1;
      @(posedge clk); #1;
      tick = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("ra_pre_valid", 32'(spk_valid), 1);
      d0 = done_count;
      reset_n = 1'b0;
      tick    = 1'b1;
      @(posedge clk); #1;
      reset_n = 1'b1;
      tick    = 1'b0;
      exp_q.delete();
      for (int i = 0; i < N; i++) begin
         model_cur[i] = 0;
         model_st[i]  = 0;
      end
      checkOutput("ra_busy", 32'(busy), 0);
      checkOutput("ra_valid", 32'(spk_valid), 0);
      checkOutput("ra_spk_idx", 32'(spk_idx), 0);
      checkStates("ra_state");
      repeat (N + 2) @(posedge clk);
      #1;
      checkOutput("ra_no_done", 32'(done_count - d0), 0);
      checkOutput("ra_tick_ignored", 32'(busy), 0);
      spk_ready = 1'b1;
      runSweep("ra_cur_cleared");
      checkStates("ra_cur_state");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lif_tdm_scheduler.md
LIF_TDM_SCHEDULER -- requirements
Module: lif_tdm_scheduler

Interface
REQ-001 Parameter N_NEUR, default 8, number of virtual neurons sharing one LIF update datapath (power of 2, 2..16).
REQ-002 Parameter THRESH, default 8, 4-bit spike threshold.
REQ-003 Parameter FIFO_DEPTH, default 4, spike-event FIFO entries (power of 2).
REQ-004 clk  in  1  clock; all state changes on rising edge.
REQ-005 reset_n  in  1  reset, synchronous, active-low.
REQ-006 cur_we  in  1  current-table write strobe.
REQ-007 cur_idx  in  log2(N_NEUR)  neuron index for the current write.
REQ-008 cur_data  in  4  input current value.
REQ-009 tick  in  1  one-cycle request to start a timestep sweep.
REQ-010 busy  out  1  high while a sweep is in progress.
REQ-011 done  out  1  one-cycle pulse when a sweep completes.
REQ-012 tick_drop  out  1  one-cycle pulse when a tick is discarded.
REQ-013 spk_valid  out  1  spike event available.
REQ-014 spk_ready  in  1  consumer accepts the event.
REQ-015 spk_idx  out  log2(N_NEUR)  index of the neuron that spiked.
REQ-016 rd_idx / rd_state  in log2(N_NEUR) / out 4  combinational peek of the membrane state.

Function
REQ-017 Storage: per-neuron 4-bit current table and 4-bit membrane-state table.
REQ-018 Each cur_we cycle writes cur_data to current[cur_idx]; currents persist until overwritten.
REQ-019 FSM states IDLE, SWEEP; IDLE->SWEEP on tick (or pending tick); SWEEP->IDLE after neuron N_NEUR-1 updates.
REQ-020 A tick accepted in IDLE at cycle t sets busy=1 at t+1; neuron k updates at the edge ending cycle t+1+k, absent stalls.
REQ-021 Update of neuron k: fired = (state[k] >= THRESH); state[k] <= current[k] + (fired ? 0 : state[k]>>1), 4-bit wrap-around, carry discarded.
REQ-022 When fired, the update pushes index k into the spike FIFO in the same edge.
REQ-023 When fired and the FIFO is full, the sweep stalls on neuron k: no state write and no index advance until a slot frees; a pop and push in the same cycle proceed without stall.
REQ-024 done pulses in the cycle after the last neuron updates; busy deasserts in that same cycle.
REQ-025 A tick during SWEEP sets a one-deep pending flag; a tick while pending is already set pulses tick_drop and is discarded.
REQ-026 A set pending flag starts a new sweep on the cycle after done, with the same timing as REQ-020.
REQ-027 When cur_we targets neuron k in its update cycle, the update uses the old current and the new value is stored for the next sweep.
REQ-028 spk_valid = FIFO non-empty; the FIFO pops on spk_valid & spk_ready; spk_idx shows the head entry, FIFO order kept.
REQ-029 rd_state reflects the table contents, including writes made in the previous cycle.

Reset
REQ-030 reset_n low at an edge clears all state and current entries to 0, empties the FIFO, clears pending, and sets FSM to IDLE.
REQ-031 Outputs during and after reset: busy=0, done=0, tick_drop=0, spk_valid=0, spk_idx=0.
REQ-032 Reset mid-sweep aborts the sweep with no done pulse; ticks in the reset cycle are ignored.

Structure
REQ-033 A shared package holds the FSM state enum, the 4-bit state/current width constant and the default THRESH.
REQ-034 The spike FIFO is a separate sub-module, lif_evt_fifo, with parameterised width and depth and full/empty flags.
REQ-035 The LIF update equation is implemented once, in the scheduler, and shared across all neurons.

Verification
REQ-036 All currents=3, one tick -> each state 0->3 after sweep 1, then 4 after sweep 2; no spikes; done pulses once per sweep.
REQ-037 current[2]=8, others 0, spk_ready=1 -> sweep 1: state[2]=8, no spike; sweep 2: spike idx 2 pushed, state[2]=8 again.
REQ-038 All currents=15, spk_ready=0, N=8, depth 4, third sweep -> stall after 4 pushes with busy held; releasing spk_ready drains events 0..7 in order, then done.
REQ-039 current=12 on neuron with state 7 -> 12+3=15; current=14, state 6 -> 14+3=17 wraps to 1.
REQ-040 Three ticks during one sweep -> one pending sweep, tick_drop pulses twice, back-to-back sweep starts the cycle after done.
REQ-041 reset_n low mid-sweep -> next cycle busy=0, spk_valid=0, all rd_state=0, no done pulse.
